axis_ramp_generator: RTL

Parametrised AXI-Stream sample generator producing up, down or triangle ramps with programmable step, limits and packet framing. Sits at the head of DSP and DMA test chains as a deterministic stimulus source; its output drives any AXIS slave (FIFO, DMA, filter) directly. Unlike a free-running counter, it honours full AXIS valid/ready semantics, frames packets with `tlast` and can be started and stopped cleanly.

---
 rtl/axis_ramp_pkg.sv | 21 ++
 rtl/axis_ramp_step.sv | 91 +++++++++
 rtl/axis_ramp_generator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/axis_ramp_pkg.sv
// Shared encodings for the AXI-Stream ramp generator: ramp modes,
// sequencer states and the triangle direction bit.
package axis_ramp_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_TRI  = 2'd2,
        MODE_HOLD = 2'd3
    } ramp_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ramp_state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/axis_ramp_step.sv
// Combinational successor calculation for the ramp value. All limit
// comparisons are done one bit wider than the counter so that data+step
// and min+step cannot overflow. A zero step freezes value and direction.
module axis_ramp_step
    import axis_ramp_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic [COUNTER_WIDTH-1:0] data,
    input  logic                     dir,
    input  ramp_mode_e               mode,
    input  logic [COUNTER_WIDTH-1:0] step,
    input  logic [COUNTER_WIDTH-1:0] lim_min,
    input  logic [COUNTER_WIDTH-1:0] lim_max,
    output logic [COUNTER_WIDTH-1:0] next_data,
    output logic                     next_dir,
    output logic                     next_wrap
);

    logic [COUNTER_WIDTH:0] data_x;
    logic [COUNTER_WIDTH:0] step_x;
    logic [COUNTER_WIDTH:0] min_x;
    logic [COUNTER_WIDTH:0] max_x;
    logic [COUNTER_WIDTH:0] up_sum;
    logic [COUNTER_WIDTH:0] min_plus;
    logic                   step_zero;

    assign data_x    = {1'b0, data};
    assign step_x    = {1'b0, step};
    assign min_x     = {1'b0, lim_min};
    assign max_x     = {1'b0, lim_max};
    assign up_sum    = data_x + step_x;
    assign min_plus  = min_x + step_x;
    assign step_zero = (step == '0);

    // Successor value, direction and period-boundary flag for the current mode
    always_comb begin
        next_data = data;
        next_dir  = dir;
        next_wrap = 1'b0;
        case (mode)
            MODE_UP: begin
                if (!step_zero) begin
                    if (up_sum > max_x) begin
                        next_data = lim_min;
                        next_wrap = 1'b1;
                    end else begin
                        next_data = up_sum[COUNTER_WIDTH-1:0];
                    end
                end
            end
            MODE_DOWN: begin
                if (!step_zero) begin
                    if (data_x < min_plus) begin
                        next_data = lim_max;
                        next_wrap = 1'b1;
                    end else begin
                        next_data = data - step;
                    end
                end
            end
            MODE_TRI: begin
                if (!step_zero) begin
                    if (dir == DIR_UP) begin
                        if (up_sum >= max_x) begin
                            next_data = lim_max;
                            next_dir  = DIR_DOWN;
                        end else begin
                            next_data = up_sum[COUNTER_WIDTH-1:0];
                        end
                    end else begin
                        if (data_x <= min_plus) begin
                            next_data = lim_min;
                            next_dir  = DIR_UP;
                            next_wrap = 1'b1;
                        end else begin
                            next_data = data - step;
                        end
                    end
                end
            end
            MODE_HOLD: begin
                next_data = lim_min;
            end
            default: begin
                next_data = data;
            end
        endcase
    end

endmodule

// File: rtl/axis_ramp_generator.sv
// AXI-Stream ramp source: up, down, triangle or constant sample streams
// with packet framing on tlast and clean start/stop.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | tvalid low; waits for cfg_enable with a legal min/max
//   ST_RUN   | streaming from latched config, one beat per handshake
//   ST_DRAIN | enable dropped; finish current packet, then go idle
//
// Config is latched on the IDLE->RUN edge and ignored afterwards, so a
// reconfiguration only takes effect on the next start.
module axis_ramp_generator
    import axis_ramp_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int COUNTER_WIDTH    = 32,
    parameter int PACKET_WIDTH     = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_enable,
    input  logic [1:0]                  cfg_mode,
    input  logic [COUNTER_WIDTH-1:0]    cfg_step,
    input  logic [COUNTER_WIDTH-1:0]    cfg_min,
    input  logic [COUNTER_WIDTH-1:0]    cfg_max,
    input  logic [PACKET_WIDTH-1:0]     cfg_packet_length,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tlast,
    output logic                        wrap,
    output logic                        cfg_error
);

    ramp_state_e              state;
    ramp_mode_e               mode_q;
    logic [COUNTER_WIDTH-1:0] step_q;
    logic [COUNTER_WIDTH-1:0] min_q;
    logic [COUNTER_WIDTH-1:0] max_q;
    logic [PACKET_WIDTH-1:0]  len_q;
    logic [COUNTER_WIDTH-1:0] data;
    logic                     dir;
    logic [PACKET_WIDTH-1:0]  beat_cnt;
    logic                     tvalid_q;
    logic                     tlast_q;
    logic                     wrap_q;
    logic                     cfg_error_q;

    logic                     handshake;
    logic [COUNTER_WIDTH-1:0] next_data;
    logic                     next_dir;
    logic                     next_wrap;
    logic [PACKET_WIDTH-1:0]  beat_next;
    logic                     tlast_next;
    ramp_mode_e               cfg_mode_e;

    assign cfg_mode_e = ramp_mode_e'(cfg_mode);
    assign handshake  = tvalid_q & M_AXIS_tready;

    // Beat counter restarts after the tlast beat; with length 0 it free-runs
    // and never matches, so tlast stays low.
    assign beat_next  = tlast_q ? '0 : beat_cnt + PACKET_WIDTH'(1);
    assign tlast_next = (len_q != '0) && (beat_next == len_q - PACKET_WIDTH'(1));

    axis_ramp_step #(
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_step (
        .data      (data),
        .dir       (dir),
        .mode      (mode_q),
        .step      (step_q),
        .lim_min   (min_q),
        .lim_max   (max_q),
        .next_data (next_data),
        .next_dir  (next_dir),
        .next_wrap (next_wrap)
    );

    // Sequencer FSM with latched config, beat counter and registered outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_UP;
            step_q      <= '0;
            min_q       <= '0;
            max_q       <= '0;
            len_q       <= '0;
            data        <= '0;
            dir         <= DIR_UP;
            beat_cnt    <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            wrap_q      <= 1'b0;
            cfg_error_q <= 1'b0;
        end else begin
            cfg_error_q <= cfg_enable && (cfg_min > cfg_max);
            wrap_q      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_enable && (cfg_min <= cfg_max)) begin
                        state    <= ST_RUN;
                        mode_q   <= cfg_mode_e;
                        step_q   <= cfg_step;
                        min_q    <= cfg_min;
                        max_q    <= cfg_max;
                        len_q    <= cfg_packet_length;
                        data     <= (cfg_mode_e == MODE_DOWN) ? cfg_max : cfg_min;
                        dir      <= DIR_UP;
                        beat_cnt <= '0;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (cfg_packet_length == PACKET_WIDTH'(1));
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if ((state == ST_RUN) && !cfg_enable) begin
                        state <= ST_DRAIN;
                    end
                    if (handshake) begin
                        // Closing beat of a drain: stop without advancing, so
                        // no stray wrap pulse appears with tvalid low.
                        if ((state == ST_DRAIN) && (tlast_q || (len_q == '0))) begin
                            state    <= ST_IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                        end else begin
                            data     <= next_data;
                            dir      <= next_dir;
                            wrap_q   <= next_wrap;
                            beat_cnt <= beat_next;
                            tlast_q  <= tlast_next;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                end
            endcase
        end
    end

    assign M_AXIS_tvalid = tvalid_q;
    assign M_AXIS_tdata  = AXIS_TDATA_WIDTH'(data);
    assign M_AXIS_tlast  = tlast_q;
    assign wrap          = wrap_q;
    assign cfg_error     = cfg_error_q;

endmodule
